// File: rtl/alm_pkg.sv
// Shared width helpers and stage flag type for the ALM pipeline.
// Widths depend on the instance WIDTH, so they are provided as constant functions.
package alm_pkg;

  localparam int DEF_WIDTH = 8;

  function automatic int frac_w(input int width);
    return width - 1;
  endfunction

  function automatic int k_w(input int width);
    return $clog2(width);
  endfunction

  function automatic int p_w(input int width);
    return 2 * width + 1;
  endfunction

  localparam int DEF_F   = frac_w(DEF_WIDTH);
  localparam int DEF_K_W = k_w(DEF_WIDTH);
  localparam int DEF_P_W = p_w(DEF_WIDTH);

  // Flags that ride with every beat through all stages.
  typedef struct packed {
    logic sign;
    logic zero;
  } sz_t;

endpackage

// File: rtl/alm_lod.sv
// Leading-one detector: k is the index of the leading one, frac the bits
// below it left-aligned into F = WIDTH-1 bits. A zero input gives k=0, frac=0.
module alm_lod
  import alm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         mag,
  output logic [$clog2(WIDTH)-1:0] k,
  output logic [WIDTH-2:0]         frac
);

  localparam int K_W = k_w(WIDTH);
  localparam int F   = frac_w(WIDTH);

  always_comb begin
    k = '0;
    for (int i = 1; i < WIDTH; i++) begin
      if (mag[i]) k = K_W'(i);
    end
    frac = F'(mag << (K_W'(F) - k));
  end

endmodule

// File: rtl/alm_soa_pipe.sv
// Three-stage Mitchell log multiplier with set-one-adder fraction sum,
// valid/ready streaming, per-beat exact/approximate mode and a sideband tag.
module alm_soa_pipe
  import alm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SOA_BITS = 2,
  parameter int TAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       x,
  input  logic [WIDTH:0]       y,
  input  logic                 exact,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH:0]     p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int F     = frac_w(WIDTH);
  localparam int K_W   = k_w(WIDTH);
  localparam int P_W   = p_w(WIDTH);
  localparam int MAG_W = 2 * WIDTH;

  typedef struct packed {
    sz_t              fl;
    logic             exact;
    logic [TAG_W-1:0] tag;
    logic [K_W-1:0]   ka;
    logic [K_W-1:0]   kb;
    logic [F-1:0]     fa;
    logic [F-1:0]     fb;
  } s1_t;

  typedef struct packed {
    sz_t              fl;
    logic [TAG_W-1:0] tag;
    logic [K_W:0]     k_sum;
    logic             c;
    logic [F-1:0]     f;
  } s2_t;

  // Most-negative operand has no positive counterpart, so it clamps to all ones.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH:0] v);
    logic [WIDTH:0] n;
    n = -v;
    if (!v[WIDTH])    return v[WIDTH-1:0];
    else if (n[WIDTH]) return {WIDTH{1'b1}};
    else              return n[WIDTH-1:0];
  endfunction

  logic             s1_v, s2_v, s3_v;
  logic             s1_en, s2_en, s3_en;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [TAG_W-1:0] tag_q;

  // Handshake: a beat moves on any rising edge where valid and ready are both 1.
  // A stage loads when empty or when its own content leaves this cycle, so
  // bubbles collapse and in_ready follows out_ready combinationally.
  assign s3_en     = !s3_v || out_ready;
  assign s2_en     = !s2_v || s3_en;
  assign s1_en     = !s1_v || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s3_v;
  assign p         = p_q;
  assign out_tag   = tag_q;

  // S1: sign, magnitude, leading-one normalisation
  logic [WIDTH-1:0] mag_x, mag_y;
  logic [K_W-1:0]   ka, kb;
  logic [F-1:0]     fa, fb;

  assign mag_x = mag_of(x);
  assign mag_y = mag_of(y);

  alm_lod #(.WIDTH(WIDTH)) u_lod_x (.mag(mag_x), .k(ka), .frac(fa));
  alm_lod #(.WIDTH(WIDTH)) u_lod_y (.mag(mag_y), .k(kb), .frac(fb));

  always_comb begin
    s1_d         = '0;
    s1_d.fl.sign = x[WIDTH] ^ y[WIDTH];
    s1_d.fl.zero = (mag_x == '0) || (mag_y == '0);
    s1_d.exact   = exact;
    s1_d.tag     = in_tag;
    s1_d.ka      = ka;
    s1_d.kb      = kb;
    s1_d.fa      = fa;
    s1_d.fb      = fb;
  end

  // S2: log-domain add; approximate mode pins the low SOA_BITS to ones
  logic [F:0] sum_exact, sum_approx;

  assign sum_exact = {1'b0, s1_q.fa} + {1'b0, s1_q.fb};

  if (SOA_BITS == 0) begin : g_no_soa
    assign sum_approx = sum_exact;
  end else begin : g_soa
    localparam int HW1 = F - SOA_BITS + 1;
    logic [HW1-1:0] hi;
    assign hi = {1'b0, s1_q.fa[F-1:SOA_BITS]} + {1'b0, s1_q.fb[F-1:SOA_BITS]}
              + HW1'(s1_q.fa[SOA_BITS-1] & s1_q.fb[SOA_BITS-1]);
    assign sum_approx = {hi, {SOA_BITS{1'b1}}};
  end

  always_comb begin
    s2_d          = '0;
    s2_d.fl       = s1_q.fl;
    s2_d.tag      = s1_q.tag;
    s2_d.k_sum    = {1'b0, s1_q.ka} + {1'b0, s1_q.kb};
    {s2_d.c, s2_d.f} = s1_q.exact ? sum_exact : sum_approx;
  end

  // S3: antilog, truncate, apply sign
  logic [K_W:0]       e;
  logic [3*WIDTH-2:0] m_ext;
  logic [MAG_W-1:0]   mag;

  always_comb begin
    e     = s2_q.k_sum + (K_W+1)'(s2_q.c);
    m_ext = {{(2*WIDTH-1){1'b0}}, 1'b1, s2_q.f};
    mag   = s2_q.fl.zero ? '0 : MAG_W'((m_ext << e) >> F);
    p_d   = s2_q.fl.sign ? -{1'b0, mag} : {1'b0, mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s3_v  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      p_q   <= '0;
      tag_q <= '0;
    end else begin
      if (s1_en) begin
        s1_v <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_en) begin
        s2_v <= s1_v;
        if (s1_v) s2_q <= s2_d;
      end
      if (s3_en) begin
        s3_v <= s2_v;
        if (s2_v) begin
          p_q   <= p_d;
          tag_q <= s2_q.tag;
        end
      end
    end
  end

endmodule
